// File: rtl/counter_slice_ctrl_pkg.sv
// Shared definitions for the dual-counter time-slicing controller.
package counter_slice_ctrl_pkg;

  localparam int unsigned CNT_W = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int unsigned SLOT0 = 0;
  localparam int unsigned SLOT1 = 1;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/counter_slice_ctrl_rr_arb2.sv
// Two-requester round-robin picker; the pointer names the favoured slot on a tie.
module rr_arb2
  import counter_slice_ctrl_pkg::*;
(
  input  logic [1:0] elig,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       index
);

  always_comb begin
    grant = 2'b00;
    index = 1'(SLOT0);
    case (elig)
      2'b01:   index = 1'(SLOT0);
      2'b10:   index = 1'(SLOT1);
      2'b11:   index = ptr;
      default: index = 1'(SLOT0);
    endcase
    if (|elig) grant = onehot2(index);
  end

endmodule

// File: rtl/counter_slice_ctrl.sv
// Time-slices the shared dual counter between two requesters and stops each
// counter exactly at its limit.
module counter_slice_ctrl
  import counter_slice_ctrl_pkg::*;
#(
  parameter int unsigned QUANTUM = 8,
  parameter int unsigned QW      = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [1:0]        Req,
  input  logic [1:0]        Clr,
  input  logic [CNT_W-1:0]  Limit0,
  input  logic [CNT_W-1:0]  Limit1,
  input  logic [CNT_W-1:0]  Cnt0,
  input  logic [CNT_W-1:0]  Cnt1,
  output logic              Slt,
  output logic              En,
  output logic [1:0]        Grant,
  output logic [1:0]        Done
);

  localparam int unsigned     PW     = CNT_W + 1;
  localparam logic [QW-1:0]   Q_LAST = QW'(QUANTUM);
  localparam logic [QW-1:0]   Q_ONE  = QW'(1);

  logic [1:0]       state, state_nx;
  logic             slt_nx, en_nx, ptr, ptr_nx;
  logic [1:0]       grant_nx, done_nx, done_set;
  logic [QW-1:0]    qcnt, qcnt_nx;
  logic [1:0]       below, elig, arb_grant;
  logic             arb_index, other_elig, reach, q_full, stop;
  logic [CNT_W-1:0] cnt_g, lim_g;
  logic [PW-1:0]    next_val;

  assign below      = {Cnt1 < Limit1, Cnt0 < Limit0};
  assign elig       = Req & ~Done & below;
  assign other_elig = Slt ? elig[SLOT0] : elig[SLOT1];

  // Slt holds the owner while running; next_val is the count after this edge.
  assign cnt_g    = Slt ? Cnt1 : Cnt0;
  assign lim_g    = Slt ? Limit1 : Limit0;
  assign next_val = {1'b0, cnt_g} + PW'(En);
  assign reach    = next_val >= {1'b0, lim_g};
  assign q_full   = qcnt == Q_LAST;

  rr_arb2 u_arb (
    .elig  (elig),
    .ptr   (ptr),
    .grant (arb_grant),
    .index (arb_index)
  );

  always_comb begin
    state_nx = state;
    slt_nx   = Slt;
    en_nx    = 1'b0;
    grant_nx = 2'b00;
    qcnt_nx  = qcnt;
    ptr_nx   = ptr;
    done_set = 2'b00;
    stop     = 1'b0;
    case (state)
      ST_IDLE: begin
        // A requester already at or past its limit is marked done, never granted.
        done_set = Req & ~below;
        if (|elig) begin
          state_nx = ST_RUN;
          slt_nx   = arb_index;
          en_nx    = 1'b1;
          grant_nx = arb_grant;
          qcnt_nx  = Q_ONE;
        end
      end
      ST_RUN: begin
        if (reach) begin
          done_set = onehot2(Slt);
          stop     = 1'b1;
        end else if (!Req[Slt]) begin
          stop = 1'b1;
        end else if (q_full && other_elig) begin
          stop = 1'b1;
        end else begin
          en_nx    = 1'b1;
          grant_nx = Grant;
          qcnt_nx  = q_full ? Q_ONE : qcnt + Q_ONE;
        end
        if (stop) begin
          state_nx = ST_GAP;
          ptr_nx   = ~Slt;
        end
      end
      ST_GAP:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    done_nx = (Done & ~Clr) | done_set;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      Slt   <= 1'b0;
      En    <= 1'b0;
      Grant <= 2'b00;
      Done  <= 2'b00;
      qcnt  <= '0;
      ptr   <= 1'(SLOT0);
    end else begin
      state <= state_nx;
      Slt   <= slt_nx;
      En    <= en_nx;
      Grant <= grant_nx;
      Done  <= done_nx;
      qcnt  <= qcnt_nx;
      ptr   <= ptr_nx;
    end
  end

endmodule
